// File: rtl/uc_pkg.sv
// Shared types and constants for the unit-clause path (collector, arbiter, queue).
package uc_pkg;

  localparam int UC_NUM_ENG  = 4;
  localparam int LIT_IDX_MAX = 100;
  localparam int UC_LIT_W    = $clog2(LIT_IDX_MAX) + 1;

  typedef logic signed [UC_LIT_W-1:0] lit_t;

  typedef enum logic {
    MODE_MASK = 1'b0,
    MODE_PQ   = 1'b1
  } input_mode_e;

endpackage

// File: rtl/uc_eng_fifo.sv
// Per-engine circular FIFO of implied literals with wrap-around pointers and an occupancy count.
module uc_eng_fifo #(
  parameter int LIT_W      = uc_pkg::UC_LIT_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic signed [LIT_W-1:0] din,
  output logic signed [LIT_W-1:0] dout,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic signed [LIT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    do_push;
  logic                    do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands at the tail.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uc_collector.sv
// Collects implied literals from every BCP engine into per-engine FIFOs and presents one
// literal stream to uc_arbiter, either by one-hot engine mask or by a round-robin merge.
module uc_collector
  import uc_pkg::*;
#(
  parameter int NUM_ENG    = UC_NUM_ENG,
  parameter int LIT_W      = UC_LIT_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_ENG*LIT_W-1:0]   eng_uc,
  input  logic [NUM_ENG-1:0]         eng_uc_valid,
  input  logic                       flush,
  input  logic                       input_mode,
  input  logic [NUM_ENG-1:0]         engmask,
  input  logic                       uca_pop,
  output logic signed [LIT_W-1:0]    eng2uca,
  output logic                       eng2uca_valid,
  output logic                       eng2uca_empty,
  output logic [NUM_ENG-1:0]         eng2uca_full,
  output logic                       overflow
);

  localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  logic [NUM_ENG-1:0]      fifo_push;
  logic [NUM_ENG-1:0]      fifo_pop;
  logic [NUM_ENG-1:0]      fifo_empty;
  logic [NUM_ENG-1:0]      fifo_full;
  logic signed [LIT_W-1:0] fifo_head [NUM_ENG];

  input_mode_e             mode_q;
  logic [PTR_W-1:0]        rr_ptr;
  logic                    sel_ok;
  logic [PTR_W-1:0]        sel_idx;
  logic                    sel_empty;
  logic signed [LIT_W-1:0] mask_lit;
  logic                    grant;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        next_ptr;
  logic signed [LIT_W-1:0] out_lit_p1;
  logic                    vld_p1;

  for (genvar i = 0; i < NUM_ENG; i++) begin : g_fifo
    logic signed [LIT_W-1:0] lit;
    assign lit = eng_uc[i*LIT_W +: LIT_W];
    // Literal 0 never names a variable, so it is discarded before it reaches the FIFO.
    assign fifo_push[i] = eng_uc_valid[i] && (lit != '0);

    uc_eng_fifo #(
      .LIT_W      (LIT_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (fifo_push[i]),
      .pop   (fifo_pop[i]),
      .din   (lit),
      .dout  (fifo_head[i]),
      .empty (fifo_empty[i]),
      .full  (fifo_full[i])
    );
  end

  always_comb begin
    sel_ok  = $onehot(engmask);
    sel_idx = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (engmask[i]) sel_idx = PTR_W'(i);
    end
    sel_empty = !sel_ok || fifo_empty[sel_idx];
    mask_lit  = sel_empty ? '0 : fifo_head[sel_idx];
  end

  always_comb begin
    int idx;
    grant     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_ENG; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_ENG;
      if (!grant && !fifo_empty[idx]) begin
        grant     = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    next_ptr = PTR_W'((int'(grant_idx) + 1) % NUM_ENG);
  end

  always_comb begin
    fifo_pop = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (mode_q == MODE_PQ) fifo_pop[i] = grant && (grant_idx == PTR_W'(i));
      else                   fifo_pop[i] = !sel_empty && uca_pop && engmask[i];
    end
  end

  // Stage p1: registered PQ grant output, round-robin pointer and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_MASK;
      rr_ptr     <= '0;
      out_lit_p1 <= '0;
      vld_p1     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      mode_q <= input_mode_e'(input_mode);
      if (flush) begin
        rr_ptr     <= '0;
        out_lit_p1 <= '0;
        vld_p1     <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (|(fifo_push & fifo_full & ~fifo_pop)) overflow <= 1'b1;
        if (mode_q == MODE_PQ && grant) begin
          out_lit_p1 <= fifo_head[grant_idx];
          vld_p1     <= 1'b1;
          rr_ptr     <= next_ptr;
        end else begin
          vld_p1 <= 1'b0;
        end
      end
    end
  end

  // A PQ result registered just before a switch to mask mode still shows for its one cycle.
  assign eng2uca       = (mode_q == MODE_PQ || vld_p1) ? out_lit_p1 : mask_lit;
  assign eng2uca_valid = vld_p1;
  assign eng2uca_empty = (mode_q == MODE_PQ) ? &fifo_empty : sel_empty;
  assign eng2uca_full  = fifo_full;

endmodule

// File: tb/tb_uc_collector.sv
// Directed bench for uc_collector: mask mode, round-robin merge, full/overflow, reset and flush.
module tb_uc_collector;
  import uc_pkg::*;

  localparam int NE = UC_NUM_ENG;
  localparam int LW = UC_LIT_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NE*LW-1:0]     eng_uc;
  logic [NE-1:0]        eng_uc_valid;
  logic                 flush;
  logic                 input_mode;
  logic [NE-1:0]        engmask;
  logic                 uca_pop;
  logic signed [LW-1:0] eng2uca;
  logic                 eng2uca_valid;
  logic                 eng2uca_empty;
  logic [NE-1:0]        eng2uca_full;
  logic                 overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uc_collector #(
    .NUM_ENG    (NE),
    .LIT_W      (LW),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .eng_uc        (eng_uc),
    .eng_uc_valid  (eng_uc_valid),
    .flush         (flush),
    .input_mode    (input_mode),
    .engmask       (engmask),
    .uca_pop       (uca_pop),
    .eng2uca       (eng2uca),
    .eng2uca_valid (eng2uca_valid),
    .eng2uca_empty (eng2uca_empty),
    .eng2uca_full  (eng2uca_full),
    .overflow      (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_lit(input int e, input int v);
    eng_uc[e*LW +: LW] = LW'(v);
    eng_uc_valid[e]    = 1'b1;
  endtask

  task automatic clr_push();
    eng_uc       = '0;
    eng_uc_valid = '0;
  endtask

  task automatic push1(input int e, input int v);
    set_lit(e, v);
    tick();
    clr_push();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; input_mode = 1'b0; uca_pop = 1'b0; engmask = '0;
    clr_push();
    tick(); tick();
    chk("rst_lit", eng2uca, 0);
    chk("rst_valid", eng2uca_valid, 0);
    chk("rst_empty", eng2uca_empty, 1);
    chk("rst_full", eng2uca_full, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    // Mask mode: engine 2 queues +5, -7
    push1(2, 5);
    push1(2, -7);
    engmask = 4'b0100;
    #1;
    chk("mask_head0", eng2uca, 5);
    chk("mask_nonempty", eng2uca_empty, 0);
    uca_pop = 1'b1;
    tick();
    chk("mask_head1", eng2uca, -7);
    tick();
    uca_pop = 1'b0;
    chk("mask_drained", eng2uca_empty, 1);
    chk("mask_empty_lit", eng2uca, 0);
    push1(2, 3);
    engmask = 4'b0110;
    #1;
    chk("mask_bad_empty", eng2uca_empty, 1);
    chk("mask_bad_lit", eng2uca, 0);
    uca_pop = 1'b1;
    tick();
    uca_pop = 1'b0;
    engmask = 4'b0100;
    #1;
    chk("mask_pop_ignored", eng2uca, 3);
    chk("mask_valid_low", eng2uca_valid, 0);
    uca_pop = 1'b1;
    tick();
    uca_pop = 1'b0;
    engmask = '0;

    // PQ round robin: engines 0,1,3 push +1,+2,+4 together
    input_mode = 1'b1;
    tick();
    set_lit(0, 1); set_lit(1, 2); set_lit(3, 4);
    tick();
    clr_push();
    chk("pq_latency", eng2uca_valid, 0);
    chk("pq_any_queued", eng2uca_empty, 0);
    tick();
    chk("pq_v0", eng2uca_valid, 1);
    chk("pq_l0", eng2uca, 1);
    tick();
    chk("pq_v1", eng2uca_valid, 1);
    chk("pq_l1", eng2uca, 2);
    tick();
    chk("pq_v2", eng2uca_valid, 1);
    chk("pq_l2", eng2uca, 4);
    tick();
    chk("pq_idle_valid", eng2uca_valid, 0);
    chk("pq_idle_hold", eng2uca, 4);
    chk("pq_idle_empty", eng2uca_empty, 1);
    set_lit(0, 6); set_lit(3, 8);
    tick();
    clr_push();
    tick();
    chk("pq_wrap_first", eng2uca, 6);
    tick();
    chk("pq_wrap_second", eng2uca, 8);
    tick();

    // Full: engine 1 pushes 9 back-to-back
    input_mode = 1'b0;
    tick(); tick();
    engmask = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      push1(1, 11 + k);
      if (k == 7) begin
        chk("full_after8", eng2uca_full, 4'b0010);
        chk("full_no_ovf_yet", overflow, 0);
      end
    end
    chk("full_ovf", overflow, 1);
    chk("full_still", eng2uca_full, 4'b0010);
    uca_pop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("full_drain%0d", k), eng2uca, 11 + k);
      tick();
    end
    uca_pop = 1'b0;
    chk("full_drained", eng2uca_empty, 1);
    chk("full_ovf_sticky", overflow, 1);
    chk("full_cleared", eng2uca_full, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ovf", overflow, 0);

    // Push and pop together on a full FIFO
    engmask = 4'b0001;
    for (int k = 0; k < 8; k++) push1(0, 21 + k);
    chk("pp_full_before", eng2uca_full, 4'b0001);
    set_lit(0, 29);
    uca_pop = 1'b1;
    tick();
    clr_push();
    uca_pop = 1'b0;
    chk("pp_full_after", eng2uca_full, 4'b0001);
    chk("pp_no_ovf", overflow, 0);
    uca_pop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("pp_drain%0d", k), eng2uca, 22 + k);
      tick();
    end
    uca_pop = 1'b0;
    chk("pp_drained", eng2uca_empty, 1);
    engmask = '0;

    // Asynchronous reset mid-stream in PQ mode
    input_mode = 1'b1;
    tick(); tick();
    for (int e = 0; e < NE; e++) set_lit(e, 31 + e);
    tick();
    clr_push();
    tick();
    chk("ar_pre_valid", eng2uca_valid, 1);
    chk("ar_pre_lit", eng2uca, 31);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", eng2uca_valid, 0);
    chk("ar_lit", eng2uca, 0);
    chk("ar_empty", eng2uca_empty, 1);
    chk("ar_full", eng2uca_full, 0);
    chk("ar_ovf", overflow, 0);
    #1 rst = 1'b0;
    tick(); tick();
    chk("ar_post_valid", eng2uca_valid, 0);
    chk("ar_post_empty", eng2uca_empty, 1);

    // Flush mid-stream in PQ mode
    for (int e = 0; e < NE; e++) set_lit(e, 41 + e);
    tick();
    clr_push();
    tick();
    chk("fl_pre_lit", eng2uca, 41);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", eng2uca_valid, 0);
    chk("fl_empty", eng2uca_empty, 1);
    chk("fl_lit", eng2uca, 0);
    tick();
    chk("fl_post_valid", eng2uca_valid, 0);

    // Literal 0 in both modes, including into a full FIFO
    push1(0, 0);
    tick();
    chk("z_pq_valid", eng2uca_valid, 0);
    chk("z_pq_empty", eng2uca_empty, 1);
    chk("z_pq_ovf", overflow, 0);
    input_mode = 1'b0;
    tick();
    engmask = 4'b0001;
    push1(0, 0);
    chk("z_mask_empty", eng2uca_empty, 1);
    chk("z_mask_ovf", overflow, 0);
    engmask = 4'b0100;
    for (int k = 0; k < 8; k++) push1(2, 51 + k);
    push1(2, 0);
    chk("z_full_ovf", overflow, 0);
    chk("z_full_flag", eng2uca_full, 4'b0100);
    chk("z_full_head", eng2uca, 51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
